mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified memory port between instruction fetch (IF state) and data access (MEMLW/MEMSW states).
//  Sits between the multi-cycle CU/datapath and the memory. Serialises one transaction at a time.
//  Returns a one-cycle ack to the owner so the CU can hold its state until memory completes.
// PARAMETERS
//  ADDR_W       32  address width, both requesters and the memory port
//  DATA_W       32  data width
//  MEM_TIMEOUT  15  watchdog limit in cycles (used only with ARB_WATCHDOG_EN); legal range 1..255
// PORTS
//  trigger    in   1       clock; all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  i_req      in   1       fetch request; held with i_addr until i_ack
//  i_addr     in   ADDR_W  fetch address
//  i_ack      out  1       one-cycle pulse: fetch complete, i_rdata valid this cycle
//  i_rdata    out  DATA_W  registered fetch data; holds until next fetch ack
//  d_req      in   1       data request; held with d_we/d_addr/d_wdata until d_ack
//  d_we       in   1       1 = store (sw), 0 = load (lw)
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_ack      out  1       one-cycle pulse: data access complete
//  d_rdata    out  DATA_W  registered load data; unchanged by stores
//  mem_en     out  1       memory request; high for the whole access
//  mem_we     out  1       memory write enable; valid while mem_en is high
//  mem_addr   out  ADDR_W  memory address; registered, stable while mem_en is high
//  mem_wdata  out  DATA_W  memory write data; registered
//  mem_rdy    in   1       memory completion; sampled only while mem_en is high
//  mem_rdata  in   DATA_W  memory read data; valid with mem_rdy
//  busy       out  1       high in BUSY_I, BUSY_D and DONE
//  err        out  1       one-cycle watchdog-abort pulse (0 without ARB_WATCHDOG_EN)
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0: mem_en, mem_we, mem_addr, mem_wdata, i_ack, d_ack, i_rdata, d_rdata, busy, err. rr_ptr=0.
//  Reset mid-access: mem_en drops on the next edge, no ack is issued, and the pending transaction is lost.
//  States: IDLE, BUSY_I, BUSY_D, DONE.
//  IDLE:
//   - Only d_req: go to BUSY_D. Only i_req: go to BUSY_I.
//   - Both: rr_ptr picks the owner (0 = data first, 1 = instr first). rr_ptr toggles on every contested grant.
//   - On the grant edge, latch the owner's addr/we/wdata into mem_*. mem_we is forced 0 for fetch. mem_en=1.
//  BUSY_x: hold mem_* constant.
//   - mem_rdy=1: mem_en goes to 0 and the state goes to DONE.
//   - For a load or fetch, mem_rdata is latched into d_rdata/i_rdata on the same edge.
//  DONE: the owner's ack is high for exactly this cycle, then IDLE.
//   - Requests are ignored in DONE. This lets the requester drop req after seeing ack, with no duplicate grant.
//  Latency: req sampled at edge N, mem_en high from N+1.
//   - With mem_rdy in the first BUSY cycle, ack is high in cycle N+2 and the next grant is possible at N+3.
//  Requests that arrive while busy wait; the requester must hold req. The losing requester is served next (rr toggle), so there is no starvation.
//  i_ack and d_ack are never high together. Exactly one ack is issued per grant.
//  Address and data are passed through unmodified; there is no alignment check.
// CONFIGURATION
//  ARB_WATCHDOG_EN defined:
//   - An 8-bit counter clears on grant and increments each BUSY cycle without mem_rdy.
//   - When the count reaches MEM_TIMEOUT: mem_en goes to 0, go to DONE, the owner's ack and err pulse together.
//   - A timed-out load/fetch returns rdata = 0.
//  ARB_WATCHDOG_EN undefined: no counter; BUSY waits indefinitely for mem_rdy; err is tied to 0.
// TESTING
//  1. Reset, then i_req=1, i_addr=0x0000_0040; mem answers mem_rdy=1 in its first cycle with 0x2008_0005
//     -> mem_en high for 1 cycle with mem_addr=0x40, mem_we=0; i_ack at N+2; i_rdata=0x2008_0005.
//  2. d_req with d_we=1, d_addr=0x100, d_wdata=0xCAFE_F00D; mem_rdy delayed 3 cycles
//     -> mem_we=1 and mem_wdata held for 4 cycles; d_ack is one pulse; d_rdata unchanged.
//  3. i_req and d_req rise together after reset, both held
//     -> data is served first (rr_ptr=0), then instr; exactly one d_ack then one i_ack; no overlap.
//  4. Requester keeps d_req high during the DONE cycle, drops it the next cycle
//     -> exactly one memory access and one d_ack (no re-grant).
//  5. rst asserted in the second BUSY_D cycle
//     -> next cycle mem_en=0, busy=0, no ack; a fresh i_req afterwards is served normally.
//  6. With ARB_WATCHDOG_EN and MEM_TIMEOUT=4, mem_rdy never asserted on a load
//     -> d_ack and err pulse together on the 6th cycle after the grant; d_rdata=0.
//     Without ARB_WATCHDOG_EN: busy stays 1 and err stays 0 for 100 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified memory port between instruction fetch and data access.
//   One transaction at a time: IDLE -> BUSY_I/BUSY_D -> DONE -> IDLE.
//   Contested requests alternate through a round-robin pointer.
//   Optional feature macro: ARB_WATCHDOG_EN adds a busy-cycle watchdog that
//   aborts a stalled access and pulses err together with the owner's ack.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              trigger,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rdy,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic              rr_ptr_q,    rr_ptr_d;     // 0 = data wins a tie, 1 = fetch wins
    logic              own_d_q,     own_d_d;      // 1 = current owner is the data side
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              i_ack_q,     i_ack_d;
    logic              d_ack_q,     d_ack_d;
    logic              err_q,       err_d;

    logic              grant_data;
    logic              finish;
    logic              aborted;
    logic [DATA_W-1:0] ret_data;

`ifdef ARB_WATCHDOG_EN
    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);
    logic [7:0] wd_cnt_q, wd_cnt_d;
`endif

    // Next-state logic: grant, completion/abort handling and ack generation
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        own_d_d     = own_d_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        err_d       = 1'b0;
        grant_data  = 1'b0;
        finish      = 1'b0;
        aborted     = 1'b0;
        ret_data    = mem_rdata;
`ifdef ARB_WATCHDOG_EN
        wd_cnt_d    = wd_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (d_req || i_req) begin
                    // Data wins when alone, or when tied and the pointer favours it
                    grant_data = d_req && (!i_req || !rr_ptr_q);
                    if (d_req && i_req) begin
                        rr_ptr_d = !rr_ptr_q;
                    end
                    own_d_d  = grant_data;
                    mem_en_d = 1'b1;
                    if (grant_data) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        state_d     = BUSY_D;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr;
                        state_d     = BUSY_I;
                    end
`ifdef ARB_WATCHDOG_EN
                    wd_cnt_d = 8'd0;
`endif
                end
            end

            BUSY_I, BUSY_D: begin
                if (mem_rdy) begin
                    finish = 1'b1;
                end
`ifdef ARB_WATCHDOG_EN
                else if (wd_cnt_q >= TIMEOUT_C) begin
                    finish  = 1'b1;
                    aborted = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
`endif
                if (finish) begin
                    // An aborted read hands back zero rather than stale bus data
                    ret_data = aborted ? '0 : mem_rdata;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    err_d    = aborted;
                    state_d  = DONE;
                    if (own_d_q) begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = ret_data;
                        end
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = ret_data;
                    end
                end
            end

            // Requests are deliberately ignored here so a requester can drop
            // its req after seeing ack without getting a second grant.
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge trigger) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            own_d_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            own_d_q     <= own_d_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            err_q       <= err_d;
        end
    end

`ifdef ARB_WATCHDOG_EN
    // Watchdog counter: cleared on grant, counts busy cycles without mem_rdy
    always_ff @(posedge trigger) begin
        if (rst) begin
            wd_cnt_q <= 8'd0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`endif

    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (ADDR_W=DATA_W=32, MEM_TIMEOUT=4).
// Watchdog scenario expectations follow the ARB_WATCHDOG_EN macro.
module tb_mem_port_arbiter;

    logic        trigger;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rdy;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_TIMEOUT(4)) dut (
        .trigger(trigger), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    initial trigger = 1'b0;
    always #5 trigger = ~trigger;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge trigger);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_rdy = 0; mem_rdata = 0;
        do_reset();
        checks++; if ({mem_en, mem_we, busy, err, i_ack, d_ack} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got en/we/busy/err/iack/dack=%b want 000000",
                               {mem_en, mem_we, busy, err, i_ack, d_ack});
        end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_mem: got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
        end
        checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got i=%h d=%h want 0", i_rdata, d_rdata);
        end
    endtask

    task automatic test_fetch();
        i_req = 1; i_addr = 32'h0000_0040;
        tick();  // grant edge
        checks++; if (mem_en !== 1 || mem_addr !== 32'h40 || mem_we !== 0 || busy !== 1 || i_ack !== 0) begin
            errors++; $display("FAIL fetch_grant: got en=%b addr=%h we=%b busy=%b iack=%b want 1 40 0 1 0",
                               mem_en, mem_addr, mem_we, busy, i_ack);
        end
        mem_rdy = 1; mem_rdata = 32'h2008_0005;
        tick();
        checks++; if (i_ack !== 1 || d_ack !== 0 || mem_en !== 0 || i_rdata !== 32'h2008_0005) begin
            errors++; $display("FAIL fetch_ack: got iack=%b dack=%b en=%b rdata=%h want 1 0 0 20080005",
                               i_ack, d_ack, mem_en, i_rdata);
        end
        mem_rdy = 0; mem_rdata = 0; i_req = 0;
        tick();
        checks++; if (i_ack !== 0 || busy !== 0) begin
            errors++; $display("FAIL fetch_idle: got iack=%b busy=%b want 0 0", i_ack, busy);
        end
    endtask

    task automatic test_store();
        bit hold_ok = 1;
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D;
        tick();
        for (int k = 1; k <= 4; k++) begin
            if (mem_en !== 1 || mem_we !== 1 || mem_addr !== 32'h100 ||
                mem_wdata !== 32'hCAFE_F00D || d_ack !== 0) hold_ok = 0;
            if (k == 4) begin
                mem_rdy = 1; mem_rdata = 32'hDEAD_BEEF;
            end
            tick();
        end
        checks++; if (hold_ok !== 1) begin
            errors++; $display("FAIL store_hold: got hold_ok=%b want 1", hold_ok);
        end
        checks++; if (d_ack !== 1 || i_ack !== 0 || mem_en !== 0) begin
            errors++; $display("FAIL store_ack: got dack=%b iack=%b en=%b want 1 0 0", d_ack, i_ack, mem_en);
        end
        checks++; if (d_rdata !== 32'h0) begin
            errors++; $display("FAIL store_rdata: got d_rdata=%h want 00000000", d_rdata);
        end
        mem_rdy = 0; mem_rdata = 0; d_req = 0; d_we = 0;
        tick();
        checks++; if (d_ack !== 0 || busy !== 0) begin
            errors++; $display("FAIL store_single: got dack=%b busy=%b want 0 0", d_ack, busy);
        end
    endtask

    // Drives both requesters together; memory answers in the first busy cycle.
    task automatic run_contested(output int first, output int second, output int nd,
                                 output int ni, output bit overlap, output logic [31:0] first_addr);
        first = 0; second = 0; nd = 0; ni = 0; overlap = 0; first_addr = 32'hFFFF_FFFF;
        i_req = 1; i_addr = 32'h200;
        d_req = 1; d_we = 0; d_addr = 32'h300;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (mem_en && first_addr === 32'hFFFF_FFFF) first_addr = mem_addr;
            if (d_ack && i_ack) overlap = 1;
            if (d_ack) begin
                nd++; if (first == 0) first = 1; else second = 1;
                d_req = 0;
            end
            if (i_ack) begin
                ni++; if (first == 0) first = 2; else second = 2;
                i_req = 0;
            end
            mem_rdy   = mem_en;
            mem_rdata = (mem_addr == 32'h300) ? 32'h1111_0300 : 32'h2222_0200;
        end
        mem_rdy = 0; mem_rdata = 0;
    endtask

    task automatic test_contested();
        int first, second, nd, ni;
        bit overlap;
        logic [31:0] fa;
        do_reset();
        run_contested(first, second, nd, ni, overlap, fa);
        checks++; if (first !== 1 || second !== 2 || fa !== 32'h300) begin
            errors++; $display("FAIL rr_round1_order: got first=%0d second=%0d addr=%h want 1 2 00000300",
                               first, second, fa);
        end
        checks++; if (nd !== 1 || ni !== 1 || overlap !== 0) begin
            errors++; $display("FAIL rr_round1_count: got nd=%0d ni=%0d overlap=%b want 1 1 0", nd, ni, overlap);
        end
        checks++; if (d_rdata !== 32'h1111_0300 || i_rdata !== 32'h2222_0200) begin
            errors++; $display("FAIL rr_round1_data: got d=%h i=%h want 11110300 22220200", d_rdata, i_rdata);
        end
        run_contested(first, second, nd, ni, overlap, fa);
        checks++; if (first !== 2 || second !== 1 || fa !== 32'h200) begin
            errors++; $display("FAIL rr_round2_order: got first=%0d second=%0d addr=%h want 2 1 00000200",
                               first, second, fa);
        end
        checks++; if (nd !== 1 || ni !== 1 || overlap !== 0) begin
            errors++; $display("FAIL rr_round2_count: got nd=%0d ni=%0d overlap=%b want 1 1 0", nd, ni, overlap);
        end
    endtask

    task automatic test_back_to_back();
        int extra = 0;
        d_req = 1; d_we = 0; d_addr = 32'h400;
        tick();
        checks++; if (mem_en !== 1 || mem_addr !== 32'h400) begin
            errors++; $display("FAIL hold_grant: got en=%b addr=%h want 1 00000400", mem_en, mem_addr);
        end
        mem_rdy = 1; mem_rdata = 32'h1234_5678;
        tick();  // DONE, d_req still held
        checks++; if (d_ack !== 1 || d_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL hold_ack: got dack=%b rdata=%h want 1 12345678", d_ack, d_rdata);
        end
        mem_rdy = 0; mem_rdata = 0;
        tick();  // back in IDLE: the held request must not have been re-granted
        checks++; if (mem_en !== 0 || d_ack !== 0 || busy !== 0) begin
            errors++; $display("FAIL hold_no_regrant: got en=%b dack=%b busy=%b want 0 0 0", mem_en, d_ack, busy);
        end
        d_req = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (mem_en || d_ack || i_ack) extra++;
        end
        checks++; if (extra !== 0) begin
            errors++; $display("FAIL hold_quiet: got activity cycles=%0d want 0", extra);
        end
    endtask

    task automatic test_reset_mid_access();
        d_req = 1; d_we = 0; d_addr = 32'h500;
        tick();  // first BUSY_D cycle
        tick();  // second BUSY_D cycle
        checks++; if (mem_en !== 1 || busy !== 1) begin
            errors++; $display("FAIL rstmid_busy: got en=%b busy=%b want 1 1", mem_en, busy);
        end
        rst = 1; mem_rdy = 1; mem_rdata = 32'h7777_7777;
        tick();
        checks++; if (mem_en !== 0 || busy !== 0 || d_ack !== 0 || i_ack !== 0) begin
            errors++; $display("FAIL rstmid_abort: got en=%b busy=%b dack=%b iack=%b want 0 0 0 0",
                               mem_en, busy, d_ack, i_ack);
        end
        rst = 0; mem_rdy = 0; mem_rdata = 0; d_req = 0;
        tick();
        checks++; if (d_ack !== 0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL rstmid_lost: got dack=%b d_rdata=%h want 0 00000000", d_ack, d_rdata);
        end
        i_req = 1; i_addr = 32'h44;
        tick();
        mem_rdy = 1; mem_rdata = 32'h0BAD_BEEF;
        tick();
        checks++; if (i_ack !== 1 || i_rdata !== 32'h0BAD_BEEF) begin
            errors++; $display("FAIL rstmid_fetch: got iack=%b rdata=%h want 1 0badbeef", i_ack, i_rdata);
        end
        mem_rdy = 0; mem_rdata = 0; i_req = 0;
        tick();
    endtask

    task automatic test_watchdog();
`ifdef ARB_WATCHDOG_EN
        bit wait_ok = 1;
        d_req = 1; d_we = 0; d_addr = 32'h600;
        tick();
        mem_rdy = 1; mem_rdata = 32'h5555_AAAA;
        tick();
        checks++; if (d_ack !== 1 || d_rdata !== 32'h5555_AAAA || err !== 0) begin
            errors++; $display("FAIL wd_preload: got dack=%b rdata=%h err=%b want 1 5555aaaa 0", d_ack, d_rdata, err);
        end
        mem_rdy = 0; mem_rdata = 32'h9999_9999; d_req = 0;
        tick();
        d_req = 1; d_addr = 32'h604;
        tick();  // grant; cycle 1 after grant
        for (int k = 1; k <= 5; k++) begin
            if (mem_en !== 1 || d_ack !== 0 || err !== 0) wait_ok = 0;
            tick();
        end
        checks++; if (wait_ok !== 1) begin
            errors++; $display("FAIL wd_wait: got wait_ok=%b want 1", wait_ok);
        end
        checks++; if (d_ack !== 1 || err !== 1 || mem_en !== 0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL wd_abort: got dack=%b err=%b en=%b rdata=%h want 1 1 0 00000000",
                               d_ack, err, mem_en, d_rdata);
        end
        d_req = 0; mem_rdata = 0;
        tick();
        checks++; if (d_ack !== 0 || err !== 0 || busy !== 0) begin
            errors++; $display("FAIL wd_after: got dack=%b err=%b busy=%b want 0 0 0", d_ack, err, busy);
        end
`else
        int bad = 0;
        d_req = 1; d_we = 0; d_addr = 32'h604;
        tick();
        for (int k = 0; k < 100; k++) begin
            if (busy !== 1 || err !== 0 || d_ack !== 0) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin
            errors++; $display("FAIL nowd_wait: got bad cycles=%0d want 0", bad);
        end
        checks++; if (mem_en !== 1 || mem_addr !== 32'h604) begin
            errors++; $display("FAIL nowd_hold: got en=%b addr=%h want 1 00000604", mem_en, mem_addr);
        end
        d_req = 0;
        do_reset();
`endif
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_contested();
        test_back_to_back();
        test_reset_mid_access();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
